// File: rtl/rf_writeback_arbiter.sv
// Register-file write port arbiter: in-order writeback (port A) versus a FIFO of
// long-latency results (port B), with a pending-write scoreboard query for decode.
module rf_writeback_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_wd,
    output logic        a_stall,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_wd,
    input  logic [4:0]  q_rs1,
    input  logic [4:0]  q_rs2,
    output logic        busy,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wd
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic [4:0]    fifo_rd_q [DEPTH];
    logic [31:0]   fifo_wd_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_rd_q, rf_rd_d;
    logic [31:0]   rf_wd_q, rf_wd_d;

    logic fifo_ne, force_b, a_win, pop, push;

    function automatic logic rd_match(input logic [4:0] r, input logic [4:0] s1,
                                      input logic [4:0] s2);
        return (r != 5'd0) && ((r == s1) || (r == s2));
    endfunction

    always_comb begin
        fifo_ne = (count_q != '0);
        force_b = fifo_ne && (starve_q == SW'(STARVE_MAX));
        a_win   = !force_b && a_valid && (a_rd != 5'd0);
        // The FIFO head goes out whenever A does not take the port.
        pop     = fifo_ne && !a_win;
        b_ready = (count_q != CW'(DEPTH));
        push    = b_valid && b_ready && (b_rd != 5'd0);
        a_stall = force_b && a_valid;
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count_q) && rd_match(fifo_rd_q[rd_ptr_q + PW'(k)], q_rs1, q_rs2)) begin
                busy = 1'b1;
            end
        end
        // The write in the output register has not reached the register file yet.
        if (rf_we_q && rd_match(rf_rd_q, q_rs1, q_rs2)) begin
            busy = 1'b1;
        end
    end

    always_comb begin
        rf_we_d  = 1'b0;
        rf_rd_d  = rf_rd_q;
        rf_wd_d  = rf_wd_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;

        if (a_win) begin
            rf_we_d = 1'b1;
            rf_rd_d = a_rd;
            rf_wd_d = a_wd;
        end else if (pop) begin
            rf_we_d = 1'b1;
            rf_rd_d = fifo_rd_q[rd_ptr_q];
            rf_wd_d = fifo_wd_q[rd_ptr_q];
        end

        if (pop || !fifo_ne) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            rf_we_q  <= 1'b0;
            rf_rd_q  <= 5'd0;
            rf_wd_q  <= 32'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            rf_we_q  <= rf_we_d;
            rf_rd_q  <= rf_rd_d;
            rf_wd_q  <= rf_wd_d;
        end
    end

    // Storage needs no reset: entries are only observed below count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q] <= b_rd;
            fifo_wd_q[wr_ptr_q] <= b_wd;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_rd = rf_rd_q;
    assign rf_wd = rf_wd_q;

endmodule
